// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - pipelined handshaked AND/OR/NOT/XOR unit with in-order result FIFO
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             zero,
    output logic             neg,
    output logic [15:0]      op_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = WIDTH + 2;

    // Entry layout: {neg, zero, result}; flags are stored so a reset head reads all-zero.
    logic [EW-1:0]   s1_entry_q, s1_entry_d;
    logic            s1_valid_q, s1_valid_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   mem_d [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     op_count_q, op_count_d;

    logic             accept;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] result;

    // Handshake status from registered state only, so out_ready never reaches in_ready.
    always_comb begin
        in_ready  = (count_q + CW'(s1_valid_q)) < CW'(DEPTH);
        out_valid = (count_q != '0);
        accept    = in_valid && in_ready;
        push      = s1_valid_q;
        pop       = out_valid && out_ready;
    end

    // Bitwise function select on the sampled operands.
    always_comb begin
        result = '0;
        case (ctrl)
            2'b00:   result = a & b;
            2'b01:   result = a | b;
            2'b10:   result = ~a;
            default: result = a ^ b;
        endcase
    end

    // Next-state for stage 1, FIFO storage, pointers and the accept counter.
    always_comb begin
        s1_valid_d = accept;
        s1_entry_d = s1_entry_q;
        if (accept) begin
            s1_entry_d = {result[WIDTH-1], (result == '0), result};
        end

        mem_d = mem_q;
        if (push) begin
            mem_d[tail_q] = s1_entry_q;
        end

        tail_d = push ? tail_q + PW'(1) : tail_q;
        head_d = pop  ? head_q + PW'(1) : head_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        op_count_d = accept ? op_count_q + 16'd1 : op_count_q;
    end

    // State registers; reset discards everything in flight and clears storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_entry_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            op_count_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_entry_q <= s1_entry_d;
            mem_q      <= mem_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            op_count_q <= op_count_d;
        end
    end

    // Head entry is always visible; consumers qualify it with out_valid.
    always_comb begin
        s        = mem_q[head_q][WIDTH-1:0];
        zero     = mem_q[head_q][WIDTH];
        neg      = mem_q[head_q][WIDTH+1];
        op_count = op_count_q;
    end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - scoreboard testbench for logic_unit_pipe
module tb_logic_unit_pipe;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             zero;
    logic             neg;
    logic [15:0]      op_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH+1:0] sb_q [$];

    logic_unit_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ctrl(ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .zero(zero), .neg(neg),
        .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                               input logic [1:0] mc);
        logic [WIDTH-1:0] r;
        case (mc)
            2'b00:   r = ma & mb;
            2'b01:   r = ma | mb;
            2'b10:   r = ~ma;
            default: r = ma ^ mb;
        endcase
        return {r, (r == '0), r[WIDTH-1]};
    endfunction

    // Scoreboard: push on accept, pop/compare on every output handshake.
    always @(negedge clk) begin
        logic [WIDTH+1:0] exp_e;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (sb_q.size() > DEPTH) begin
                check("occupancy", sb_q.size(), DEPTH);
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(a, b, ctrl));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("pop_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_e = sb_q.pop_front();
                    check("pop_data", {s, zero, neg}, exp_e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic [1:0] ic);
        bit acc;
        acc = 1'b0;
        a = ia; b = ib; ctrl = ic; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            acc = in_ready;
            step();
            if (acc) break;
        end
        in_valid = 1'b0;
        check("send_accepted", acc, 1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (sb_q.size() == 0 && !out_valid) break;
            step();
        end
        check("drain_empty", sb_q.size(), 0);
    endtask

    task automatic opcode_case(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic [1:0] ic,
                               input logic [WIDTH-1:0] es, input logic ez, input logic en);
        a = ia; b = ib; ctrl = ic; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("lat_k_valid", out_valid, 0);
        step();
        check("lat_k1_valid", out_valid, 1);
        check("op_s", s, es);
        check("op_zero", zero, ez);
        check("op_neg", neg, en);
        step();
        check("lat_k2_popped", out_valid, 0);
    endtask

    initial begin
        int idx;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; ctrl = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_op_count", op_count, 0);
        check("rst_s", s, 0);
        check("rst_zero", zero, 0);
        check("rst_neg", neg, 0);

        // Opcodes with immediate consumption
        out_ready = 1'b1;
        opcode_case(8'd5, 8'd3,     2'b00, 8'd1,     1'b0, 1'b0);
        opcode_case(8'd5, 8'hFA,    2'b01, 8'hFF,    1'b0, 1'b1);
        opcode_case(8'd5, 8'h77,    2'b10, 8'hFA,    1'b0, 1'b1);
        opcode_case(8'd5, 8'd5,     2'b11, 8'h00,    1'b1, 1'b0);
        check("op_count_4", op_count, 4);

        // Backpressure: DEPTH accepts, then stall
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(8'(16 + i), 8'(8'hF0 - i), 2'(i));
        end
        a = 8'h3C; b = 8'hA5; ctrl = 2'b11; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("full_in_ready", in_ready, 0);
            step();
        end
        check("full_op_count", op_count, 8);
        out_ready = 1'b1;
        check("no_comb_ready", in_ready, 0);
        step();
        check("ready_after_pop", in_ready, 1);
        send(8'h3C, 8'hA5, 2'b11);
        send(8'h81, 8'h18, 2'b01);
        drain();
        check("bp_op_count", op_count, 10);

        // Streaming back-to-back
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a = 8'($urandom); b = 8'($urandom); ctrl = 2'($urandom); in_valid = 1'b1;
            check("stream_no_bubble", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        drain();

        // Random output backpressure
        idx = 0;
        for (int cyc = 0; cyc < 20000 && idx < 1000; cyc++) begin
            bit acc;
            out_ready = 1'($urandom);
            if (!in_valid) begin
                a = 8'($urandom); b = 8'($urandom); ctrl = 2'($urandom); in_valid = 1'b1;
            end
            acc = in_ready;
            step();
            if (acc) begin
                in_valid = 1'b0;
                idx++;
            end
        end
        in_valid = 1'b0;
        check("rand_all_accepted", idx, 1000);
        drain();

        // Reset with queued results
        out_ready = 1'b0;
        send(8'h11, 8'h22, 2'b01);
        send(8'h33, 8'h44, 2'b00);
        send(8'h55, 8'h66, 2'b11);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_out_valid", out_valid, 0);
        check("rst2_op_count", op_count, 0);
        check("rst2_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst2_no_stale", out_valid, 0);
        end

        // op_count wrap and FIFO pointer wrap
        for (int i = 0; i < 65537; i++) begin
            a = 8'($urandom); b = 8'($urandom); ctrl = 2'($urandom); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("op_count_wrap", op_count, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
